// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the SAP RAM bus arbiter.
// Imported by the arbiter top and its owner-select mux.
package ram_arb_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        CPU_OWN = 2'd0,
        DRAIN   = 2'd1,
        LD_OWN  = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    // Which requester drives the RAM this cycle; SEL_IDLE is the turnaround gap.
    typedef enum logic [1:0] {
        SEL_CPU  = 2'd0,
        SEL_LD   = 2'd1,
        SEL_IDLE = 2'd2
    } ram_sel_t;

endpackage

// File: rtl/ram_arb_mux.sv
// Combinational owner-select mux between the CPU datapath and the loader.
// The non-owner always sees zero read data.
module ram_arb_mux
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  ram_sel_t          sel,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic              ld_rd,
    input  logic              ld_wr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic [DATA_W-1:0] ld_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_re,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        ram_addr  = cpu_addr;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = cpu_wdata;
        cpu_rdata = '0;
        ld_rdata  = '0;
        case (sel)
            SEL_CPU: begin
                ram_re    = cpu_rd;
                ram_we    = cpu_wr;
                cpu_rdata = ram_rdata;
            end
            SEL_LD: begin
                ram_addr  = ld_addr;
                ram_re    = ld_rd;
                ram_we    = ld_wr;
                ram_wdata = ld_wdata;
                ld_rdata  = ram_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Arbitrates the SAP program/data RAM between the CPU and an external loader.
// Grants only at fetch1, stalls the CPU during loader ownership, revokes after MAX_HOLD.
module ram_bus_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_HOLD = 64,
    parameter int HOLD_W   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_boundary,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ld_req,
    output logic              ld_gnt,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic              ld_rd,
    input  logic              ld_wr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic [DATA_W-1:0] ld_rdata,
    output logic [ADDR_W:0]   ld_wr_cnt,
    output logic              ld_revoked,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_re,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [ADDR_W:0] WR_MAX = {1'b1, {ADDR_W{1'b0}}};

    arb_state_t        state, state_next;
    ram_sel_t          sel;
    logic [HOLD_W-1:0] hold_cnt;
    logic [ADDR_W:0]   wr_cnt;
    logic              revoked;
    logic              rearm;
    logic              timeout;
    logic              grant_now;

    assign timeout   = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    assign grant_now = (state == DRAIN) && ld_req && cpu_boundary;

    // State updates on the falling edge to line up with the SAP control unit.
    always_ff @(negedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        if (rst) state <= CPU_OWN;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            CPU_OWN: if (ld_req && rearm) state_next = DRAIN;
            DRAIN: begin
                if (!ld_req)          state_next = CPU_OWN;
                else if (cpu_boundary) state_next = LD_OWN;
            end
            LD_OWN:  if (timeout || !ld_req) state_next = RELEASE;
            RELEASE: state_next = CPU_OWN;
            default: state_next = CPU_OWN;
        endcase
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
            wr_cnt   <= '0;
            revoked  <= 1'b0;
            rearm    <= 1'b1;
        end else begin
            if (grant_now) begin
                hold_cnt <= '0;
                wr_cnt   <= '0;
                revoked  <= 1'b0;
            end
            if (state == LD_OWN) begin
                hold_cnt <= hold_cnt + 1'b1;
                if (ld_wr && (wr_cnt != WR_MAX)) wr_cnt <= wr_cnt + 1'b1;
                if (timeout) begin
                    revoked <= 1'b1;
                    rearm   <= 1'b0;
                end
            end
            // A dropped request always re-arms, even in the cycle a timeout fires.
            if (!ld_req) rearm <= 1'b1;
        end
    end

    always_comb begin
        case (state)
            LD_OWN:  sel = SEL_LD;
            RELEASE: sel = SEL_IDLE;
            default: sel = SEL_CPU;
        endcase
    end

    assign ld_gnt     = (state == LD_OWN);
    assign cpu_stall  = (state == LD_OWN) || (state == RELEASE) || ((state == DRAIN) && cpu_boundary);
    assign ld_wr_cnt  = wr_cnt;
    assign ld_revoked = revoked;

    ram_arb_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mux (
        .sel       (sel),
        .cpu_addr  (cpu_addr),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .ld_addr   (ld_addr),
        .ld_rd     (ld_rd),
        .ld_wr     (ld_wr),
        .ld_wdata  (ld_wdata),
        .ld_rdata  (ld_rdata),
        .ram_addr  (ram_addr),
        .ram_re    (ram_re),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Scoreboard bench for ram_bus_arbiter: stimulus pushes expected outputs from an
// ownership-level reference model; a monitor on the rising edge pops and compares.
module tb_ram_bus_arbiter;

    localparam int AW       = 4;
    localparam int DW       = 8;
    localparam int MAX_HOLD = 64;
    localparam int HW       = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          cpu_boundary = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic          cpu_rd = 1'b0;
    logic          cpu_wr = 1'b0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          ld_req = 1'b0;
    logic          ld_gnt;
    logic [AW-1:0] ld_addr = '0;
    logic          ld_rd = 1'b0;
    logic          ld_wr = 1'b0;
    logic [DW-1:0] ld_wdata = '0;
    logic [DW-1:0] ld_rdata;
    logic [AW:0]   ld_wr_cnt;
    logic          ld_revoked;
    logic [AW-1:0] ram_addr;
    logic          ram_re;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    ram_bus_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_HOLD (MAX_HOLD),
        .HOLD_W   (HW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_boundary (cpu_boundary),
        .cpu_addr     (cpu_addr),
        .cpu_rd       (cpu_rd),
        .cpu_wr       (cpu_wr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_stall    (cpu_stall),
        .ld_req       (ld_req),
        .ld_gnt       (ld_gnt),
        .ld_addr      (ld_addr),
        .ld_rd        (ld_rd),
        .ld_wr        (ld_wr),
        .ld_wdata     (ld_wdata),
        .ld_rdata     (ld_rdata),
        .ld_wr_cnt    (ld_wr_cnt),
        .ld_revoked   (ld_revoked),
        .ram_addr     (ram_addr),
        .ram_re       (ram_re),
        .ram_we       (ram_we),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    typedef struct {
        int            cyc;
        bit            data_care;
        logic          gnt;
        logic          stall;
        logic          re;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] cpu_rdata;
        logic [DW-1:0] ld_rdata;
        logic [AW:0]   wr_cnt;
        logic          revoked;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Reference model: who holds the RAM and for how long, in plain terms.
    bit m_loader_owns = 0;
    bit m_waiting     = 0;
    bit m_turnaround  = 0;
    int m_held        = 0;
    int m_writes      = 0;
    bit m_revoked     = 0;
    bit m_armed       = 1;

    task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, c, act, req);
        end
    endtask

    task automatic model_reset();
        m_loader_owns = 0;
        m_waiting     = 0;
        m_turnaround  = 0;
        m_held        = 0;
        m_writes      = 0;
        m_revoked     = 0;
        m_armed       = 1;
    endtask

    task automatic rnd_data();
        cpu_addr  = AW'($urandom);
        cpu_wdata = DW'($urandom);
        ld_addr   = AW'($urandom);
        ld_wdata  = DW'($urandom);
        ram_rdata = DW'($urandom);
    endtask

    // Issue one clock period of the current inputs, queueing the expected response.
    task automatic step(input bit push);
        exp_t e;
        if (push) begin
            e.cyc       = cyc;
            e.gnt       = m_loader_owns;
            e.stall     = m_loader_owns || m_turnaround || (m_waiting && cpu_boundary);
            e.wr_cnt    = (AW + 1)'(m_writes);
            e.revoked   = m_revoked;
            e.data_care = !m_turnaround;
            if (m_loader_owns) begin
                e.addr = ld_addr;  e.re = ld_rd;  e.we = ld_wr;  e.wdata = ld_wdata;
                e.cpu_rdata = '0;  e.ld_rdata = ram_rdata;
            end else if (m_turnaround) begin
                e.addr = '0;  e.re = 1'b0;  e.we = 1'b0;  e.wdata = '0;
                e.cpu_rdata = '0;  e.ld_rdata = '0;
            end else begin
                e.addr = cpu_addr;  e.re = cpu_rd;  e.we = cpu_wr;  e.wdata = cpu_wdata;
                e.cpu_rdata = ram_rdata;  e.ld_rdata = '0;
            end
            exp_q.push_back(e);
        end

        if (rst) begin
            model_reset();
        end else if (m_loader_owns) begin
            m_held++;
            if (ld_wr) m_writes = (m_writes + 1 > 16) ? 16 : m_writes + 1;
            if (m_held == MAX_HOLD) begin
                m_revoked = 1;
                m_armed   = 0;
                m_loader_owns = 0;
                m_turnaround  = 1;
            end else if (!ld_req) begin
                m_loader_owns = 0;
                m_turnaround  = 1;
            end
            if (!ld_req) m_armed = 1;
        end else if (m_turnaround) begin
            m_turnaround = 0;
            if (!ld_req) m_armed = 1;
        end else if (m_waiting) begin
            if (!ld_req) begin
                m_waiting = 0;
                m_armed   = 1;
            end else if (cpu_boundary) begin
                m_waiting     = 0;
                m_loader_owns = 1;
                m_held        = 0;
                m_writes      = 0;
                m_revoked     = 0;
            end
        end else begin
            if (!ld_req)      m_armed   = 1;
            else if (m_armed) m_waiting = 1;
        end

        @(negedge clk);
        #1;
        cyc++;
    endtask

    // Monitor: outputs are stable mid-cycle, on the edge opposite the state update.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ld_gnt",     e.cyc, 32'(ld_gnt),     32'(e.gnt));
                check("cpu_stall",  e.cyc, 32'(cpu_stall),  32'(e.stall));
                check("ram_re",     e.cyc, 32'(ram_re),     32'(e.re));
                check("ram_we",     e.cyc, 32'(ram_we),     32'(e.we));
                check("ld_wr_cnt",  e.cyc, 32'(ld_wr_cnt),  32'(e.wr_cnt));
                check("ld_revoked", e.cyc, 32'(ld_revoked), 32'(e.revoked));
                if (e.data_care) begin
                    check("ram_addr",  e.cyc, 32'(ram_addr),  32'(e.addr));
                    check("ram_wdata", e.cyc, 32'(ram_wdata), 32'(e.wdata));
                    check("cpu_rdata", e.cyc, 32'(cpu_rdata), 32'(e.cpu_rdata));
                    check("ld_rdata",  e.cyc, 32'(ld_rdata),  32'(e.ld_rdata));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset: the first edge establishes a known state, the second is checked.
        rst = 1'b1;
        #1;
        step(0);
        step(1);
        rst = 1'b0;

        // Idle CPU read.
        cpu_rd = 1'b1;  cpu_addr = 4'h3;  ram_rdata = 8'hA5;
        step(1);

        // Request outside fetch1 for 3 cycles, then a boundary grants.
        ld_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rnd_data();
            cpu_boundary = 1'b0;  cpu_rd = 1'($urandom);  cpu_wr = 1'($urandom);
            step(1);
        end
        cpu_boundary = 1'b1;
        step(1);

        // Loader writes every address, then two more to hit saturation.
        for (int i = 0; i < 18; i++) begin
            rnd_data();
            ld_addr = AW'(i);  ld_wr = 1'b1;  ld_rd = 1'($urandom);
            cpu_wr = 1'b1;     cpu_boundary = 1'($urandom);
            step(1);
        end

        // Release: LD_OWN -> RELEASE -> CPU_OWN.
        ld_req = 1'b0;  ld_wr = 1'b0;  cpu_wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rnd_data();
            step(1);
        end

        // Timeout: hold the request well past MAX_HOLD.
        ld_req = 1'b1;  cpu_boundary = 1'b1;
        step(1);
        step(1);
        for (int i = 0; i < MAX_HOLD + 8; i++) begin
            rnd_data();
            ld_wr = 1'($urandom);  ld_rd = 1'($urandom);
            cpu_rd = 1'($urandom); cpu_wr = 1'($urandom);
            cpu_boundary = 1'($urandom);
            step(1);
        end

        // Drop the request for one cycle, then re-request at a boundary.
        ld_req = 1'b0;
        step(1);
        ld_req = 1'b1;  cpu_boundary = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rnd_data();
            ld_wr = 1'($urandom);
            step(1);
        end

        // Reset during loader ownership with a write in flight.
        ld_wr = 1'b1;  rst = 1'b1;
        step(1);
        rst = 1'b0;  ld_req = 1'b0;  cpu_wr = 1'b1;
        step(1);
        cpu_wr = 1'b0;
        step(1);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rnd_data();
            cpu_rd = 1'($urandom);  cpu_wr = 1'($urandom);
            ld_rd  = 1'($urandom);  ld_wr  = 1'($urandom);
            if ($urandom_range(7) == 0) ld_req = ~ld_req;
            cpu_boundary = ($urandom_range(3) == 0);
            rst = ($urandom_range(99) == 0);
            step(1);
        end
        rst = 1'b0;  ld_req = 1'b0;
        step(1);
        step(1);

        check("queue_empty", cyc, 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_bus_arbiter.md
Name: ram_bus_arbiter

Overview:
- Shares the single program/data RAM between the SAP CPU datapath and an external program loader.
- Sits between the control-unit-driven MAR/RAM signals and the RAM macro.
- Hands ownership to the loader only at an instruction boundary (fetch1), stalls the control unit while the loader owns RAM, and forcibly reclaims RAM after a bounded hold time.

Parameters:
- ADDR_W, 4, RAM address width.
- DATA_W, 8, RAM data width.
- MAX_HOLD, 64, maximum cycles the loader may own RAM per grant; 0 = unlimited.
- HOLD_W, 7, width of hold counter; must hold MAX_HOLD.

Ports:
- clk  in  1  system clock; all state updates on falling edge, matching control unit.
- rst  in  1  synchronous, active-high reset.
- cpu_boundary  in  1  high while control unit is in fetch1 state.
- cpu_addr  in  ADDR_W  MAR output.
- cpu_rd  in  1  CPU RAM read enable (RAM-to-bus).
- cpu_wr  in  1  CPU RAM write enable (STA).
- cpu_wdata  in  DATA_W  bus data for CPU write.
- cpu_rdata  out  DATA_W  RAM read data to CPU.
- cpu_stall  out  1  control unit must hold its current state while high.
- ld_req  in  1  loader ownership request (level).
- ld_gnt  out  1  loader owns RAM.
- ld_addr  in  ADDR_W  loader address.
- ld_rd  in  1  loader read enable.
- ld_wr  in  1  loader write enable.
- ld_wdata  in  DATA_W  loader write data.
- ld_rdata  out  DATA_W  RAM read data to loader.
- ld_wr_cnt  out  ADDR_W+1  writes performed in current/last grant, saturating.
- ld_revoked  out  1  sticky: last grant ended by MAX_HOLD timeout.
- ram_addr  out  ADDR_W  to RAM.
- ram_re  out  1  to RAM.
- ram_we  out  1  to RAM.
- ram_wdata  out  DATA_W  to RAM.
- ram_rdata  in  DATA_W  from RAM.

Behaviour:
- States: CPU_OWN, DRAIN, LD_OWN, RELEASE; encoding in package.
- Reset (synchronous, falling edge with rst=1):
  - state=CPU_OWN; ld_gnt=0; cpu_stall=0; hold_cnt=0; ld_wr_cnt=0; ld_revoked=0; rearm=1.
  - rst overrides any state, including mid-grant; loader ownership is lost immediately.
- CPU_OWN:
  - RAM muxed to cpu_*; ld_rdata=0.
  - ld_req=1 and rearm=1 -> DRAIN.
- DRAIN:
  - CPU still owns RAM and runs.
  - cpu_stall = cpu_boundary (combinational), so the CPU freezes in fetch1.
  - ld_req=0 -> CPU_OWN (abort).
  - ld_req=1 and cpu_boundary=1 -> LD_OWN; clear hold_cnt and ld_wr_cnt; clear ld_revoked.
- LD_OWN:
  - ld_gnt=1; cpu_stall=1; RAM muxed to ld_*.
  - cpu_rd/cpu_wr are ignored; cpu_rdata=0.
  - Each cycle with ld_wr=1 increments ld_wr_cnt, saturating at 2^ADDR_W.
  - hold_cnt increments each cycle.
  - ld_req=0 -> RELEASE.
  - MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 -> RELEASE, with ld_revoked=1 and rearm=0.
  - If both conditions hold in the same cycle, the timeout wins (ld_revoked=1).
- RELEASE:
  - One turnaround cycle: ld_gnt=0; cpu_stall=1; ram_re=ram_we=0.
  - Always -> CPU_OWN.
- Re-arm: rearm is set again when ld_req=0 is sampled in any state. After a revoke, the loader must drop ld_req for at least one cycle before the next grant.
- Ownership latency:
  - ld_req rise to ld_gnt: 1 cycle if cpu_boundary is already high in DRAIN, otherwise until the next fetch1 edge.
  - ld_req fall to CPU resume: 2 edges (LD_OWN -> RELEASE -> CPU_OWN).
- Simultaneous rd and wr from the same owner: both are passed through. The RAM writes and ram_rdata reflects the pre-write contents.
- RAM-side outputs are combinational from the state register and the selected requester; there is no added latency.
- ld_wr_cnt holds its value after release until the next grant.

Decomposition:
- Package ram_arb_pkg holds:
  - state encoding localparams (CPU_OWN=2'd0, DRAIN=2'd1, LD_OWN=2'd2, RELEASE=2'd3);
  - default widths (ADDR_W, DATA_W).
- One sub-module, ram_arb_mux: a purely combinational owner-select mux for addr/re/we/wdata and rdata steering. The FSM and counters stay in the top module.

Test Plan:
- Reset then idle: cpu_rd=1, cpu_addr=4'h3, ram_rdata=8'hA5 -> ram_addr=3, ram_re=1, cpu_rdata=A5, cpu_stall=0, ld_gnt=0.
- Grant at boundary:
  - Stimulus: ld_req=1 with cpu_boundary=0 for 3 cycles, then cpu_boundary=1.
  - Response: ld_gnt stays 0 during the 3 cycles; cpu_stall=1 in the boundary cycle; ld_gnt=1 on the next edge.
- Loader writes: grant held, ld_wr=1 at addresses 0..15 (16 writes), then 2 more writes -> ld_wr_cnt=16 (saturated); ram_we tracks ld_wr; cpu_wr=1 during grant does not reach RAM.
- Release: drop ld_req -> one RELEASE cycle with ld_gnt=0, cpu_stall=1, ram_we=0; next cycle cpu_stall=0 and the CPU owns RAM.
- Timeout with MAX_HOLD=4:
  - Stimulus: ld_req held high.
  - Response: ld_gnt high for exactly 4 cycles; ld_revoked=1; no re-grant while ld_req stays high; after ld_req 1->0->1 plus a boundary, grant is reissued and ld_revoked=0.
- Reset mid-grant: rst=1 during LD_OWN with ld_wr=1 -> next edge state CPU_OWN, ld_gnt=0, cpu_stall=0, ld_wr_cnt=0, ram_we follows cpu_wr only.
